// File: rtl/gpio_proto_pkg.sv
// Shared definitions for the 32-bit GPIO command protocol between the host master
// and the accelerator-side control block.
package gpio_proto_pkg;

  localparam logic [2:0] OP_KERNEL = 3'd0;
  localparam logic [2:0] OP_ISIZE  = 3'd1;
  localparam logic [2:0] OP_IMAGE  = 3'd2;
  localparam logic [2:0] OP_DREQ   = 3'd3;
  localparam logic [2:0] OP_RUN    = 3'd4;
  localparam logic [2:0] OP_PRST   = 3'd7;

  localparam int RST_BIT   = 0;
  localparam int DATA_LSB  = 1;
  localparam int DATA_MSB  = 24;
  localparam int VALID_BIT = 28;
  localparam int CTRL_LSB  = 29;
  localparam int CTRL_MSB  = 31;
  localparam int DATA_W    = 24;
  localparam int ISIZE_W   = 10;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_DRIVE    = 3'd1;
  localparam state_t ST_GAP      = 3'd2;
  localparam state_t ST_SAMPLE   = 3'd3;
  localparam state_t ST_WAIT_EOP = 3'd4;
  localparam state_t ST_PRST     = 3'd5;
  localparam state_t ST_RESP     = 3'd6;

  // Ops 0..4 are serialised onto the bus with a valid pulse.
  function automatic logic op_is_drive(input logic [2:0] op);
    return (op <= OP_RUN);
  endfunction

endpackage

// File: rtl/gpio_word_pack.sv
// Combinational packing of reset, data, valid and ctrl fields into the GPIO word.
module gpio_word_pack
  import gpio_proto_pkg::*;
(
  input  logic              i_rst_bit,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic [2:0]        i_ctrl,
  output logic [31:0]       o_word
);

  // Bits [27:25] stay zero.
  always_comb begin
    o_word                     = 32'h0;
    o_word[RST_BIT]            = i_rst_bit;
    o_word[DATA_MSB:DATA_LSB]  = i_data;
    o_word[VALID_BIT]          = i_valid;
    o_word[CTRL_MSB:CTRL_LSB]  = i_ctrl;
  end

endmodule

// File: rtl/gpio_host_master.sv
// Host-side master: serialises queued commands onto the GPIO word with a timed
// valid pulse, samples returned data or waits for end-of-processing, then responds.
module gpio_host_master
  import gpio_proto_pkg::*;
#(
  parameter int VALID_HOLD  = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int RSP_LAT     = 3,
  parameter int RST_CYCLES  = 8,
  parameter int EOP_TIMEOUT = 2**20,
  parameter int BITS_DATA   = 13
) (
  input  logic                 CLK100MHZ,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  input  logic [2:0]           i_cmd_op,
  input  logic [23:0]          i_cmd_data,
  output logic                 o_cmd_ready,
  output logic [31:0]          o_gpio,
  input  logic [31:0]          i_gpio,
  input  logic                 i_eop,
  output logic                 o_rsp_valid,
  output logic [BITS_DATA-1:0] o_rsp_data,
  output logic                 o_rsp_err,
  output logic                 o_busy
);

  localparam int MAX_A    = (VALID_HOLD > GAP_CYCLES) ? VALID_HOLD : GAP_CYCLES;
  localparam int MAX_B    = (RSP_LAT > RST_CYCLES) ? RSP_LAT : RST_CYCLES;
  localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_HOLD = (MAX_C > EOP_TIMEOUT) ? MAX_C : EOP_TIMEOUT;
  localparam int CNT_W    = $clog2(MAX_HOLD + 1);

  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] VH_LAST  = CNT_W'(VALID_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RSP_LAT - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] EOP_LAST = CNT_W'(EOP_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc_s;
  logic [2:0]           op_q, op_d;
  logic [2:0]           ctrl_q, ctrl_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 err_q, err_d;
  logic [BITS_DATA-1:0] sample_q, sample_d;
  logic [31:0]          gpio_q, gpio_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [BITS_DATA-1:0] rsp_data_q, rsp_data_d;
  logic                 accept_s;
  logic                 unused_gpio_s;

  assign accept_s      = i_cmd_valid & ready_q;
  assign cnt_inc_s     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  assign unused_gpio_s = ^i_gpio;

  // Command sequencer: every phase restarts the counter on exit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc_s;
    op_d     = op_q;
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    err_d    = err_q;
    sample_d = sample_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (accept_s) begin
          op_d     = i_cmd_op;
          err_d    = 1'b0;
          sample_d = {BITS_DATA{1'b0}};
          if (op_is_drive(i_cmd_op)) begin
            ctrl_d  = i_cmd_op;
            data_d  = (i_cmd_op == OP_ISIZE) ? {14'h0, i_cmd_data[ISIZE_W-1:0]} : i_cmd_data;
            state_d = ST_DRIVE;
          end else if (i_cmd_op == OP_PRST) begin
            ctrl_d  = 3'd0;
            data_d  = {DATA_W{1'b0}};
            state_d = ST_PRST;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == VH_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_GAP;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          case (op_q)
            OP_DREQ: state_d = ST_SAMPLE;
            OP_RUN:  state_d = ST_WAIT_EOP;
            default: state_d = ST_RESP;
          endcase
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d    = {CNT_W{1'b0}};
          sample_d = i_gpio[BITS_DATA-1:0];
          state_d  = ST_RESP;
        end else begin
          state_d = ST_SAMPLE;
        end
      end
      ST_WAIT_EOP: begin
        if (i_eop) begin
          cnt_d   = {CNT_W{1'b0}};
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == EOP_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT_EOP;
        end
      end
      ST_PRST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RESP;
        end else begin
          state_d = ST_PRST;
        end
      end
      ST_RESP: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // The bus word follows the next state so it is in phase with the FSM.
  gpio_word_pack u_pack (
    .i_rst_bit (state_d == ST_PRST),
    .i_data    (data_d),
    .i_valid   (state_d == ST_DRIVE),
    .i_ctrl    (ctrl_d),
    .o_word    (gpio_d)
  );

  // Handshake and response outputs.
  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_q == ST_RESP);
    rsp_err_d   = rsp_valid_d & err_q;
    rsp_data_d  = rsp_valid_d ? sample_q : {BITS_DATA{1'b0}};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK100MHZ) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      op_q        <= 3'd0;
      ctrl_q      <= 3'd0;
      data_q      <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
      sample_q    <= {BITS_DATA{1'b0}};
      gpio_q      <= 32'h0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= {BITS_DATA{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      err_q       <= err_d;
      sample_q    <= sample_d;
      gpio_q      <= gpio_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_busy      = busy_q;
  assign o_gpio      = gpio_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_gpio_host_master.sv
// Directed, table-driven bench for gpio_host_master with a short EOP timeout.
module tb_gpio_host_master;

  logic        CLK100MHZ = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic [2:0]  i_cmd_op;
  logic [23:0] i_cmd_data;
  logic        o_cmd_ready;
  logic [31:0] o_gpio;
  logic [31:0] i_gpio;
  logic        i_eop;
  logic        o_rsp_valid;
  logic [12:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0]  op;
    logic [23:0] data;
    logic [31:0] igpio;
    logic [31:0] drive_w;
    logic [31:0] gap_w;
    int          lat;
    logic        err;
    logic [12:0] rdata;
  } vec_t;

  vec_t vecs[6];

  gpio_host_master #(
    .VALID_HOLD (4),
    .GAP_CYCLES (4),
    .RSP_LAT    (3),
    .RST_CYCLES (8),
    .EOP_TIMEOUT(100),
    .BITS_DATA  (13)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_data  (i_cmd_data),
    .o_cmd_ready (o_cmd_ready),
    .o_gpio      (o_gpio),
    .i_gpio      (i_gpio),
    .i_eop       (i_eop),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a command for one edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [23:0] data);
    i_cmd_op    = op;
    i_cmd_data  = data;
    i_cmd_valid = 1'b1;
    step();
    i_cmd_valid = 1'b0;
  endtask

  initial begin
    int k;
    int lat;
    int hi_cnt;
    logic seen;

    vecs[0] = '{3'd0, 24'h030201, 32'h0, 32'h1006_0402, 32'h0006_0402, 9, 1'b0, 13'h0};
    vecs[1] = '{3'd1, 24'hFFF3FF, 32'h0, 32'h3000_07FE, 32'h2000_07FE, 9, 1'b0, 13'h0};
    vecs[2] = '{3'd2, 24'hABCDEF, 32'h0, 32'h5157_9BDE, 32'h4157_9BDE, 9, 1'b0, 13'h0};
    vecs[3] = '{3'd3, 24'h000005, 32'hFFFF_1ABC, 32'h7000_000A, 32'h6000_000A, 12, 1'b0, 13'h1ABC};
    vecs[4] = '{3'd5, 24'h123456, 32'h0, 32'h6000_000A, 32'h6000_000A, 1, 1'b1, 13'h0};
    vecs[5] = '{3'd6, 24'h654321, 32'h0, 32'h6000_000A, 32'h6000_000A, 1, 1'b1, 13'h0};

    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_op    = 3'd0;
    i_cmd_data  = 24'h0;
    i_gpio      = 32'h0;
    i_eop       = 1'b0;

    for (int r = 0; r < 3; r++) begin
      step();
      check($sformatf("rst%0d_gpio", r), o_gpio, 32'h0);
      check($sformatf("rst%0d_ready", r), {31'h0, o_cmd_ready}, 32'h1);
      check($sformatf("rst%0d_busy", r), {31'h0, o_busy}, 32'h0);
      check($sformatf("rst%0d_rsp", r), {31'h0, o_rsp_valid}, 32'h0);
    end
    i_rst = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      i_gpio = vecs[v].igpio;
      issue(vecs[v].op, vecs[v].data);
      check($sformatf("v%0d_busy", v), {31'h0, o_busy}, 32'h1);
      check($sformatf("v%0d_ready", v), {31'h0, o_cmd_ready}, 32'h0);
      k   = 0;
      lat = -1;
      while (k <= 200) begin
        if (k == 0 || k == 3) check($sformatf("v%0d_drive_k%0d", v, k), o_gpio, vecs[v].drive_w);
        if (k == 4 || k == 7) check($sformatf("v%0d_gap_k%0d", v, k), o_gpio, vecs[v].gap_w);
        if (o_rsp_valid) begin
          lat = k;
          break;
        end
        step();
        k++;
      end
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d_err", v), {31'h0, o_rsp_err}, {31'h0, vecs[v].err});
      check($sformatf("v%0d_data", v), {19'h0, o_rsp_data}, {19'h0, vecs[v].rdata});
      step();
      check($sformatf("v%0d_strobe", v), {31'h0, o_rsp_valid}, 32'h0);
      check($sformatf("v%0d_idle", v), {30'h0, o_cmd_ready, o_busy}, 32'h2);
    end

    // Run command with EOP arriving 50 cycles after the gap ends.
    issue(3'd4, 24'h0);
    seen = 1'b0;
    for (int c = 1; c <= 58; c++) begin
      step();
      if (o_rsp_valid) seen = 1'b1;
      if (c == 20) check("run_wait_gpio", o_gpio, 32'h8000_0000);
    end
    check("run_early_rsp", {31'h0, seen}, 32'h0);
    i_eop = 1'b1;
    step();
    check("run_k59_rsp", {31'h0, o_rsp_valid}, 32'h0);
    step();
    check("run_k60_rsp", {31'h0, o_rsp_valid}, 32'h1);
    check("run_k60_err", {31'h0, o_rsp_err}, 32'h0);
    i_eop = 1'b0;
    step();

    // Run command that times out: EOP never rises.
    issue(3'd4, 24'h0);
    k   = 0;
    lat = -1;
    while (k <= 300) begin
      if (o_rsp_valid) begin
        lat = k;
        break;
      end
      step();
      k++;
    end
    check("tmo_latency", lat, 109);
    check("tmo_err", {31'h0, o_rsp_err}, 32'h1);
    step();

    // Peripheral reset pulse.
    issue(3'd7, 24'hFFFFFF);
    k      = 0;
    lat    = -1;
    hi_cnt = 0;
    while (k <= 100) begin
      if (o_gpio[0]) hi_cnt++;
      if (k == 0) check("prst_gpio_k0", o_gpio, 32'h0000_0001);
      if (o_rsp_valid) begin
        lat = k;
        break;
      end
      step();
      k++;
    end
    check("prst_high_cycles", hi_cnt, 8);
    check("prst_latency", lat, 9);
    check("prst_gpio_after", o_gpio, 32'h0);
    check("prst_err", {31'h0, o_rsp_err}, 32'h0);
    step();

    // Reset asserted in the middle of DRIVE aborts without a response.
    issue(3'd0, 24'h123456);
    step();
    check("abort_drive_valid", {31'h0, o_gpio[28]}, 32'h1);
    i_rst = 1'b1;
    step();
    check("abort_gpio", o_gpio, 32'h0);
    check("abort_idle", {30'h0, o_cmd_ready, o_busy}, 32'h2);
    i_rst = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (o_rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", {31'h0, seen}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
